// File: rtl/hazard_pkg.sv
// Shared decode tables for the hazard controller: opcode/funct constants,
// Tuse/Tnew encodings and per-instruction decode helpers.
package hazard_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef logic [1:0] tval_t;

  localparam tval_t TUSE_0    = 2'd0;
  localparam tval_t TUSE_1    = 2'd1;
  localparam tval_t TUSE_2    = 2'd2;
  localparam tval_t TUSE_NONE = 2'd3;
  localparam tval_t TNEW_0    = 2'd0;
  localparam tval_t TNEW_1    = 2'd1;
  localparam tval_t TNEW_2    = 2'd2;

  typedef enum logic [1:0] {
    MD_NONE,
    MD_MULT,
    MD_DIV,
    MD_HILO
  } md_kind_e;

  function automatic logic sp(input logic [31:0] ir,
                              input logic [5:0]  fn);
    sp = (ir[31:26] == OP_SPECIAL) && (ir[5:0] == fn);
  endfunction

  function automatic logic is_alu_r(input logic [31:0] ir);
    is_alu_r = sp(ir, FN_ADDU) || sp(ir, FN_SUBU);
  endfunction

  function automatic logic is_muldiv(input logic [31:0] ir);
    is_muldiv = sp(ir, FN_MULT) || sp(ir, FN_MULTU) ||
                sp(ir, FN_DIV)  || sp(ir, FN_DIVU);
  endfunction

  function automatic md_kind_e md_kind_of(input logic [31:0] ir);
    md_kind_of = MD_NONE;
    unique case (1'b1)
      sp(ir, FN_MULT), sp(ir, FN_MULTU): md_kind_of = MD_MULT;
      sp(ir, FN_DIV),  sp(ir, FN_DIVU):  md_kind_of = MD_DIV;
      sp(ir, FN_MFHI), sp(ir, FN_MFLO),
      sp(ir, FN_MTHI), sp(ir, FN_MTLO):  md_kind_of = MD_HILO;
      default:                           md_kind_of = MD_NONE;
    endcase
  endfunction

  function automatic logic [4:0] a3_of(input logic [31:0] ir);
    logic [5:0] op;
    op    = ir[31:26];
    a3_of = 5'd0;
    unique case (1'b1)
      is_alu_r(ir) || sp(ir, FN_MFHI) || sp(ir, FN_MFLO):
        a3_of = ir[15:11];
      op == OP_ORI || op == OP_LUI || op == OP_LW:
        a3_of = ir[20:16];
      op == OP_JAL:
        a3_of = 5'd31;
      default:
        a3_of = 5'd0;
    endcase
  endfunction

  function automatic tval_t tnew_of(input logic [31:0] ir);
    logic [5:0] op;
    op      = ir[31:26];
    tnew_of = TNEW_0;
    unique case (1'b1)
      is_alu_r(ir) || sp(ir, FN_MFHI) || sp(ir, FN_MFLO) ||
      op == OP_ORI || op == OP_LUI:
        tnew_of = TNEW_1;
      op == OP_LW:
        tnew_of = TNEW_2;
      default:
        tnew_of = TNEW_0;
    endcase
  endfunction

  function automatic tval_t tuse_rs_of(input logic [31:0] ir);
    logic [5:0] op;
    op         = ir[31:26];
    tuse_rs_of = TUSE_NONE;
    unique case (1'b1)
      op == OP_BEQ || sp(ir, FN_JR):
        tuse_rs_of = TUSE_0;
      is_alu_r(ir) || is_muldiv(ir) ||
      op == OP_ORI || op == OP_LW || op == OP_SW ||
      sp(ir, FN_MTHI) || sp(ir, FN_MTLO):
        tuse_rs_of = TUSE_1;
      default:
        tuse_rs_of = TUSE_NONE;
    endcase
  endfunction

  function automatic tval_t tuse_rt_of(input logic [31:0] ir);
    logic [5:0] op;
    op         = ir[31:26];
    tuse_rt_of = TUSE_NONE;
    unique case (1'b1)
      op == OP_BEQ:                  tuse_rt_of = TUSE_0;
      is_alu_r(ir) || is_muldiv(ir): tuse_rt_of = TUSE_1;
      op == OP_SW:                   tuse_rt_of = TUSE_2;
      default:                       tuse_rt_of = TUSE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div busy counter: loads the unit latency on a start and counts
// down to idle; md_busy is high while the count is non-zero.
module md_busy_cnt #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CLOG = $clog2(MAXC + 1);
  localparam int CW   = (CLOG > 4) ? CLOG : 4;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (md_start)
      cnt_d = md_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign md_busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Tnew/Tuse stall and flush controller for the 5-stage MIPS pipeline.
// Define HAZARD_MD_STALL_EN to add the mult/div busy tracking and stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  output logic        PC_En,
  output logic        D_En,
  output logic        E_Clr,
  output logic        md_start,
  output logic        md_busy
);

  logic [4:0] rs_d, rt_d, a3_e, a3_m;
  tval_t      tuse_rs, tuse_rt;
  tval_t      tnew_e, tnew_em, tnew_m;
  logic       hit_rs, hit_rt;
  logic       data_stall, md_stall, stall;

  assign rs_d    = IR_D[25:21];
  assign rt_d    = IR_D[20:16];
  assign a3_e    = a3_of(IR_E);
  assign a3_m    = a3_of(IR_M);
  assign tuse_rs = tuse_rs_of(IR_D);
  assign tuse_rt = tuse_rt_of(IR_D);
  assign tnew_e  = tnew_of(IR_E);
  assign tnew_em = tnew_of(IR_M);
  assign tnew_m  = (tnew_em != TNEW_0) ? tnew_em - 2'd1 : TNEW_0;

  // $0 is hard-wired, so a match on register 0 is never a hazard
  assign hit_rs = (rs_d != 5'd0) &&
                  ((rs_d == a3_e && tnew_e > tuse_rs) ||
                   (rs_d == a3_m && tnew_m > tuse_rs));
  assign hit_rt = (rt_d != 5'd0) &&
                  ((rt_d == a3_e && tnew_e > tuse_rt) ||
                   (rt_d == a3_m && tnew_m > tuse_rt));

  assign data_stall = hit_rs | hit_rt;

`ifdef HAZARD_MD_STALL_EN
  md_kind_e kind_e, kind_d;

  assign kind_e   = md_kind_of(IR_E);
  assign kind_d   = md_kind_of(IR_D);
  assign md_start = (kind_e == MD_MULT) || (kind_e == MD_DIV);
  assign md_stall = (kind_d != MD_NONE) && (md_start || md_busy);

  md_busy_cnt #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk     (clk),
    .reset   (reset),
    .md_start(md_start),
    .md_div  (kind_e == MD_DIV),
    .md_busy (md_busy)
  );
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ reset;
  assign md_start       = 1'b0;
  assign md_busy        = 1'b0;
  assign md_stall       = 1'b0;
`endif

  assign stall = data_stall | md_stall;
  assign PC_En = ~stall;
  assign D_En  = ~stall;
  assign E_Clr = stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: table-driven reference model,
// directed pipeline scenarios and randomized IR triples.
module tb_hazard_ctrl;

`ifdef HAZARD_MD_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] IR_D = '0, IR_E = '0, IR_M = '0;
  logic        PC_En, D_En, E_Clr, md_start, md_busy;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
    .PC_En(PC_En), .D_En(D_En), .E_Clr(E_Clr),
    .md_start(md_start), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  // Mnemonic tables: NOP ADDU SUBU ORI LUI LW SW BEQ J JAL JR
  //                  MULT MULTU DIV DIVU MFHI MFLO MTHI MTLO
  localparam int NI = 19;
  localparam int OPC [NI] = '{0, 0, 0, 'h0d, 'h0f, 'h23, 'h2b, 'h04,
    'h02, 'h03, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam int FN  [NI] = '{0, 'h21, 'h23, 0, 0, 0, 0, 0, 0, 0,
    'h08, 'h18, 'h19, 'h1a, 'h1b, 'h10, 'h12, 'h11, 'h13};
  localparam int DSEL[NI] = '{0,1,1,2,2,2,0,0,0,3,0,0,0,0,0,1,1,0,0};
  localparam int TNEW[NI] = '{0,1,1,1,1,2,0,0,0,0,0,0,0,0,0,1,1,0,0};
  localparam int URS [NI] = '{3,1,1,1,3,1,1,0,3,3,0,1,1,1,1,3,3,1,1};
  localparam int URT [NI] = '{3,1,1,3,3,3,2,0,3,3,3,1,1,1,1,3,3,3,3};
  localparam int KIND[NI] = '{0,0,0,0,0,0,0,0,0,0,0,1,1,2,2,3,3,3,3};

  localparam int ADDU = 1, LW = 5, BEQ = 7, MULT = 11, DIV = 13;
  localparam int MFHI = 15, MFLO = 16;

  typedef struct packed {
    logic st;
    logic ms;
    logic mb;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   rem = 0;
  int   obs_stall = 0;
  logic last_stall = 1'b0;

  function automatic int mnem(input logic [31:0] ir);
    mnem = 0;
    for (int i = 1; i < NI; i++)
      if (ir[31:26] == 6'(OPC[i]) && (OPC[i] != 0 || ir[5:0] == 6'(FN[i])))
        mnem = i;
  endfunction

  function automatic logic [31:0] enc(input int idx, input int rs,
                                      input int rt, input int rd);
    if (idx == 0)
      enc = '0;
    else if (OPC[idx] == 0)
      enc = {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(FN[idx])};
    else if (idx == 8 || idx == 9)
      enc = {6'(OPC[idx]), 26'h10};
    else
      enc = {6'(OPC[idx]), 5'(rs), 5'(rt), 16'h0004};
  endfunction

  function automatic int dest(input logic [31:0] ir);
    case (DSEL[mnem(ir)])
      1:       dest = int'(ir[15:11]);
      2:       dest = int'(ir[20:16]);
      3:       dest = 31;
      default: dest = 0;
    endcase
  endfunction

  function automatic logic data_hz(input logic [31:0] d, e, m);
    int id, te, tm, de, dm;
    int src [2];
    int use_c [2];
    id = mnem(d);
    te = TNEW[mnem(e)];
    tm = (TNEW[mnem(m)] > 0) ? TNEW[mnem(m)] - 1 : 0;
    de = dest(e);
    dm = dest(m);
    src[0] = int'(d[25:21]);
    src[1] = int'(d[20:16]);
    use_c[0] = URS[id];
    use_c[1] = URT[id];
    data_hz = 1'b0;
    for (int k = 0; k < 2; k++)
      if (src[k] != 0 && ((src[k] == de && te > use_c[k]) ||
                          (src[k] == dm && tm > use_c[k])))
        data_hz = 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] d, e, m);
    exp_t x;
    int   ke;
    logic start, busy;
    @(posedge clk);
    #1;
    reset = r;
    IR_D = d;
    IR_E = e;
    IR_M = m;
    if (!r) rem = 0;
    ke    = KIND[mnem(e)];
    start = MD_EN && (ke == 1 || ke == 2);
    busy  = rem > 0;
    x.st  = data_hz(d, e, m) ||
            (MD_EN && KIND[mnem(d)] != 0 && (start || busy));
    x.ms  = start;
    x.mb  = busy;
    q.push_back(x);
    last_stall = x.st;
    if (r) begin
      if (start)        rem = (ke == 2) ? DIV_N : MULT_N;
      else if (rem > 0) rem = rem - 1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    #1;
    chk("queue drained", q.size(), 0);
  endtask

  // Advance a tiny D/E/M pipeline, inserting bubbles where the model stalls
  task automatic pipe(input logic [31:0] d0, e0, m0, input int cycles);
    logic [31:0] d, e, m;
    d = d0;
    e = e0;
    m = m0;
    for (int c = 0; c < cycles; c++) begin
      step(1'b1, d, e, m);
      m = e;
      if (last_stall) e = '0;
      else begin
        e = d;
        d = '0;
      end
    end
  endtask

  task automatic run_stalls(input string name, input logic [31:0] d, e,
                            input int cycles, input int req);
    drain();
    obs_stall = 0;
    pipe(d, e, '0, cycles);
    drain();
    chk(name, obs_stall, req);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("E_Clr", int'(E_Clr), int'(x.st));
      chk("PC_En", int'(PC_En), int'(!x.st));
      chk("D_En", int'(D_En), int'(!x.st));
      chk("md_start", int'(md_start), int'(x.ms));
      chk("md_busy", int'(md_busy), int'(x.mb));
      if (E_Clr) obs_stall++;
    end
  end

  initial begin
    step(1'b0, '0, '0, '0);
    step(1'b0, '0, '0, '0);
    step(1'b1, '0, '0, '0);

    run_stalls("lw-addu stalls", enc(ADDU, 1, 3, 2), enc(LW, 0, 1, 0), 4, 1);
    run_stalls("lw-beq stalls", enc(BEQ, 1, 0, 0), enc(LW, 0, 1, 0), 5, 2);
    run_stalls("lw0 stalls", enc(ADDU, 0, 0, 2), enc(LW, 0, 0, 0), 4, 0);
    run_stalls("mult-mflo stalls", enc(MFLO, 0, 0, 3), enc(MULT, 1, 2, 0),
               10, MD_EN ? 1 + MULT_N : 0);
    run_stalls("div-mfhi stalls", enc(MFHI, 0, 0, 3), enc(DIV, 1, 2, 0),
               15, MD_EN ? 1 + DIV_N : 0);

    run_stalls("div cut stalls", enc(MFHI, 0, 0, 3), enc(DIV, 1, 2, 0),
               4, MD_EN ? 4 : 0);
    step(1'b0, '0, '0, '0);
    step(1'b1, '0, '0, '0);
    step(1'b1, enc(MFLO, 0, 0, 4), '0, '0);
    drain();

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ir [3];
      for (int s = 0; s < 3; s++) begin
        int idx;
        idx = int'($urandom_range(0, NI));
        if (idx == NI) ir[s] = $urandom;
        else ir[s] = enc(idx, int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)));
      end
      step(1'b1, ir[0], ir[1], ir[2]);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Stall/flush controller for the 5-stage MIPS pipeline. It decodes the instructions in D, E and M and generates the D→E flush (`E_Clr`) consumed by the E pipeline register. It also generates the PC/D-register hold enables and the mult/div start and busy tracking. All decisions use the Tuse/Tnew model, and the block sits beside the D-stage decode logic.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles after a mult/multu start.
- `DIV_CYCLES`, default 10: busy cycles after a div/divu start.

Ports:
- `clk`, input, 1: pipeline clock, rising edge.
- `reset`, input, 1: asynchronous, active-low; clears the busy counter.
- `IR_D`, input, 32: instruction in D.
- `IR_E`, input, 32: instruction in E.
- `IR_M`, input, 32: instruction in M.
- `PC_En`, output, 1: PC write enable; equals `~stall`.
- `D_En`, output, 1: D register write enable; equals `~stall`.
- `E_Clr`, output, 1: bubble into E on the next edge; equals `stall`.
- `md_start`, output, 1: the instruction in E is mult/multu/div/divu.
- `md_busy`, output, 1: the mult/div unit is still computing.

## Operation
- Supported set: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo. Any other encoding has no write and no source use (treated as nop).
- Destination `A3`:
  - rd for addu/subu/mfhi/mflo.
  - rt for ori/lui/lw.
  - 31 for jal.
  - 0 otherwise.
- Tuse, in cycles until the value is needed, measured from D:
  - beq rs/rt = 0; jr rs = 0.
  - addu/subu/mult*/div* rs,rt = 1.
  - ori/lw/mthi/mtlo rs = 1.
  - sw rs = 1, rt = 2.
  - Unused operand = 3 (never stalls).
- Tnew at E:
  - addu/subu/ori/lui/mfhi/mflo = 1.
  - lw = 2.
  - jal = 0.
  - No write = 0.
- Tnew at M = max(Tnew_E_of_IR_M − 1, 0).
- `data_stall` is 1 when, for src in {rs, rt} of IR_D, src ≠ 0 and either:
  - src == A3(IR_E) and Tnew_E > Tuse(src), or
  - src == A3(IR_M) and Tnew_M > Tuse(src).
- Busy counter `cnt`, 4 bits minimum, sized to hold max(MULT_CYCLES, DIV_CYCLES):
  - If `md_start`: load MULT_CYCLES or DIV_CYCLES.
  - Else if `cnt ≠ 0`: decrement.
  - `md_busy = (cnt ≠ 0)`.
- `md_stall` is 1 when IR_D is any mult/div/mfhi/mflo/mthi/mtlo and (`md_start` or `md_busy`).
- `stall = data_stall | md_stall`.
- E never stalls, so every IR_E is seen for exactly one cycle and each start is counted once.

## Timing
- `stall`, `E_Clr`, `PC_En`, `D_En` and `md_start` are combinational from the IR inputs and `cnt`; no added latency.
- `cnt` updates on the `clk` rising edge.
- Reset (`reset` = 0) clears `cnt` immediately, with no clock needed. With all IRs equal to 0, outputs are `PC_En=1`, `D_En=1`, `E_Clr=0`, `md_start=0`, `md_busy=0`.
- Reset asserted mid-operation aborts the busy count. Once `reset` is released, `md_stall` depends only on the next `md_start`.
- Boundary rules:
  - A new `md_start` while `cnt ≠ 0` reloads the counter; this is unreachable in legal flow, since D is held.
  - Data stall and md stall in the same cycle give a single stall.
  - `$0` never causes a data stall.
- Stall lengths:
  - Mult in E with mflo in D: 1 + MULT_CYCLES stall cycles.
  - Div: 1 + DIV_CYCLES stall cycles.

## Configuration
- `HAZARD_MD_STALL_EN` defined: busy counter and `md_stall` are present as described above.
- `HAZARD_MD_STALL_EN` undefined:
  - No counter; `md_busy` and `md_start` are tied 0 and `md_stall = 0`.
  - Mult/div instructions are still decoded for data hazards only.

## Structure
- Shared package `hazard_pkg` holds:
  - Opcode/funct constants for the supported set.
  - The 2-bit Tuse/Tnew encodings, including the constant TUSE_NONE = 3.
  - The decode functions `a3_of`, `tnew_of`, `tuse_rs_of` and `tuse_rt_of`.
- Sub-module `md_busy_cnt`: counter with load/decrement, the two parameters, `clk` and `reset` ports, and `md_busy` output. It is instantiated only under `HAZARD_MD_STALL_EN`.

## Test plan
- `lw $1,0($0)` in E, `addu $2,$1,$3` in D → `stall=1` for 1 cycle, then 0 once lw is in M.
- `lw $1` in E, `beq $1,$0` in D → `stall=1` for 2 consecutive cycles, with `E_Clr=1` each cycle.
- `lw $0,0($0)` in E, `addu $2,$0,$0` in D → `stall=0`.
- `mult $1,$2` in E, `mflo $3` in D → `md_start=1`, then `md_busy=1` for 5 cycles; `stall=1` for exactly 6 cycles.
- `div` in E, `mfhi` in D → 11 stall cycles. Drive `reset=0` at stall cycle 4 → `md_busy=0` immediately, and `stall=0` with IRs at 0.
- Build without `HAZARD_MD_STALL_EN`, then mult in E, mflo in D → `stall=0`, `md_busy=0`.
